// File: rtl/lfsr_period_meter_if.sv
// Bundle for lfsr_period_meter: the observed LFSR taps/state, the start request and
// the measurement results.
//   master : drives taps, lfsr_in and start; receives busy, done, valid, timeout, period
//   slave  : the meter itself
// Optional: LFSR_PERIOD_MAXLEN_EN adds the maxlen result flag.
interface lfsr_period_meter_if #(
   parameter int unsigned LFSRSIZE = 8
);
   logic [LFSRSIZE-1:0] taps;
   logic [LFSRSIZE-1:0] lfsr_in;
   logic                start;
   logic                busy;
   logic                done;
   logic                valid;
   logic                timeout;
   logic [LFSRSIZE:0]   period;
`ifdef LFSR_PERIOD_MAXLEN_EN
   logic                maxlen;
`endif

`ifdef LFSR_PERIOD_MAXLEN_EN
   modport master (
      output taps, lfsr_in, start,
      input  busy, done, valid, timeout, period, maxlen
   );
   modport slave (
      input  taps, lfsr_in, start,
      output busy, done, valid, timeout, period, maxlen
   );
`else
   modport master (
      output taps, lfsr_in, start,
      input  busy, done, valid, timeout, period
   );
   modport slave (
      input  taps, lfsr_in, start,
      output busy, done, valid, timeout, period
   );
`endif
endinterface

// File: rtl/lfsr_period_meter.sv
// lfsr_period_meter: measures the period of an LFSR sequence on request. After start
// (and a settle delay) it captures the current LFSR state as a reference and counts
// cycles until that state recurs, or reports a timeout after 2^LFSRSIZE counts.
// A change of the taps bus restarts the measurement, since the LFSR re-initialises.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : lfsr_period_meter_if slave modport
//          taps, lfsr_in (observed LFSR), start (request, sampled only when idle),
//          busy, done (1-cycle pulse), valid, timeout, period (0 on timeout)
// Optional feature: define LFSR_PERIOD_MAXLEN_EN to add bus.maxlen, set with the result
// when the period equals 2^LFSRSIZE-1 (maximal length) and cleared on start.
module lfsr_period_meter #(
   parameter int unsigned LFSRSIZE = 8,
   parameter int unsigned SETTLE   = 2
) (
   input logic                clk,
   input logic                rst,
   lfsr_period_meter_if.slave bus
);

   localparam int unsigned CW       = LFSRSIZE + 1;
   localparam int unsigned SW       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SW-1:0] SettleLd = SW'(SETTLE);
   localparam logic [CW-1:0] CntMax   = {1'b1, {LFSRSIZE{1'b0}}};
`ifdef LFSR_PERIOD_MAXLEN_EN
   localparam logic [CW-1:0] MaxLenPeriod = {1'b0, {LFSRSIZE{1'b1}}};
`endif

   typedef enum logic [1:0] {StIdle, StSettle, StArm, StCount} state_e;

   state_e              state_q;
   logic [LFSRSIZE-1:0] taps_q;
   logic [SW-1:0]       scnt_q;
   logic [CW-1:0]       cnt_q;
   logic [LFSRSIZE-1:0] ref_q;
   logic                done_q;
   logic                valid_q;
   logic                timeout_q;
   logic [CW-1:0]       period_q;
`ifdef LFSR_PERIOD_MAXLEN_EN
   logic                maxlen_q;
`endif

   logic tchg;
   assign tchg = (bus.taps != taps_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         taps_q    <= '0;
         scnt_q    <= '0;
         cnt_q     <= '0;
         ref_q     <= '0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         period_q  <= '0;
`ifdef LFSR_PERIOD_MAXLEN_EN
         maxlen_q  <= 1'b0;
`endif
      end else begin
         taps_q <= bus.taps;
         done_q <= 1'b0;
         // A taps change while measuring means the LFSR restarted: begin again,
         // discarding the partial count. This wins over a same-cycle match.
         if ((state_q != StIdle) && tchg) begin
            state_q <= StSettle;
            scnt_q  <= SettleLd;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.start) begin
                     state_q   <= StSettle;
                     scnt_q    <= SettleLd;
                     valid_q   <= 1'b0;
                     timeout_q <= 1'b0;
`ifdef LFSR_PERIOD_MAXLEN_EN
                     maxlen_q  <= 1'b0;
`endif
                  end
               end
               StSettle: begin
                  if (scnt_q == '0) begin
                     state_q <= StArm;
                  end else begin
                     scnt_q <= scnt_q - SW'(1);
                  end
               end
               StArm: begin
                  ref_q   <= bus.lfsr_in;
                  cnt_q   <= CW'(1);
                  state_q <= StCount;
               end
               StCount: begin
                  if (bus.lfsr_in == ref_q) begin
                     period_q  <= cnt_q;
                     valid_q   <= 1'b1;
                     timeout_q <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= StIdle;
`ifdef LFSR_PERIOD_MAXLEN_EN
                     maxlen_q  <= (cnt_q == MaxLenPeriod);
`endif
                  end else if (cnt_q == CntMax) begin
                     // Reference is off-cycle (non-invertible taps): it never recurs.
                     period_q  <= '0;
                     valid_q   <= 1'b1;
                     timeout_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= StIdle;
`ifdef LFSR_PERIOD_MAXLEN_EN
                     maxlen_q  <= 1'b0;
`endif
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.done    = done_q;
   assign bus.valid   = valid_q;
   assign bus.timeout = timeout_q;
   assign bus.period  = period_q;
`ifdef LFSR_PERIOD_MAXLEN_EN
   assign bus.maxlen  = maxlen_q;
`endif

endmodule
